// File: rtl/seq_rotate_right.sv
// Multi-cycle rotate-right unit: accepts a word and an amount over valid/ready, rotates right
// one bit per clock, then holds the result until the consumer takes it.
module seq_rotate_right #(
    parameter int WIDTH = 4,
    parameter int SHW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d     = data_in;
                    count_d    = amt;
                    in_ready_d = 1'b0;
                    if (amt == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        busy_d  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                data_d  = {data_q[0], data_q[WIDTH-1:1]};
                count_d = count_q - SHW'(1);
                // Leaving at count==1 keeps the counter from ever wrapping below zero.
                if (count_q == SHW'(1)) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // in_ready is held low while reset is asserted so every output reads zero during reset.
    assign in_ready  = in_ready_q & ~rst;
    assign out_valid = out_valid_q;
    assign data_out  = data_q;
    assign busy      = busy_q;

endmodule
